dn_lut_loader: RTL

DN_LUT_LOADER -- requirements
Module: dn_lut_loader

---
 rtl/dn_lut_loader_pkg.sv | 16 +
 rtl/dn_lut_loader.sv | 126 ++++++++++++
 2 files changed

// File: rtl/dn_lut_loader_pkg.sv
// rtl/dn_lut_loader_pkg.sv - shared page geometry and FSM state encodings for dn_lut_loader
`ifndef DN_LOAD_CYCLE
`define DN_LOAD_CYCLE 32
`endif

package dn_lut_loader_pkg;

    localparam int DN_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } dn_state_e;

endpackage

// File: rtl/dn_lut_loader.sv
// rtl/dn_lut_loader.sv - streams one DN LUT page into two replicated LUT write ports
// Optional page parity check enabled by defining DN_LOADER_PARITY_EN.
module dn_lut_loader
    import dn_lut_loader_pkg::*;
#(
    parameter int DN_LOAD_CYCLE = `DN_LOAD_CYCLE,
    parameter int ADDR_W        = DN_ADDR_W
) (
    input  logic              write_clk,
    input  logic              rstn,
    input  logic              load_start,
    input  logic              src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic              lut_in_replicate_0,
    output logic              lut_in_replicate_1,
    output logic [ADDR_W-1:0] write_addr_replicate_0,
    output logic [ADDR_W-1:0] write_addr_replicate_1,
    output logic              we,
    output logic              load_busy,
    output logic              load_done
`ifdef DN_LOADER_PARITY_EN
    ,
    input  logic              src_parity,
    output logic              parity_err
`endif
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DN_LOAD_CYCLE - 1);

    dn_state_e         r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_we;
    logic              r_load_done;

    // Each LUT copy gets its own driver so the two fanout trees stay separate.
    (* keep = "true" *) logic [ADDR_W-1:0] r_addr_0;
    (* keep = "true" *) logic [ADDR_W-1:0] r_addr_1;
    (* keep = "true" *) logic              r_data_0;
    (* keep = "true" *) logic              r_data_1;

    logic w_loading;
    logic w_accept;
    logic w_last;
    logic w_start;

    assign w_loading = (r_state == ST_LOAD);
    assign w_accept  = w_loading && src_valid;
    assign w_last    = (r_cnt == LAST_IDX);
    assign w_start   = (r_state == ST_IDLE) && load_start;

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_load_done <= 1'b0;
            r_addr_0    <= '0;
            r_addr_1    <= '0;
            r_data_0    <= 1'b0;
            r_data_1    <= 1'b0;
        end else begin
            r_we        <= w_accept;
            r_load_done <= 1'b0;
            if (w_accept) begin
                r_addr_0 <= r_cnt;
                r_addr_1 <= r_cnt;
                r_data_0 <= src_data;
                r_data_1 <= src_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (load_start) begin
                        r_state <= ST_LOAD;
                        r_cnt   <= '0;
                    end
                end
                ST_LOAD: begin
                    // The counter parks on the last index; the next page clears it on start.
                    if (w_accept) begin
                        if (w_last) begin
                            r_state     <= ST_DONE;
                            r_load_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign src_ready              = w_loading;
    assign load_busy              = w_loading;
    assign we                     = r_we;
    assign load_done              = r_load_done;
    assign write_addr_replicate_0 = r_addr_0;
    assign write_addr_replicate_1 = r_addr_1;
    assign lut_in_replicate_0     = r_data_0;
    assign lut_in_replicate_1     = r_data_1;

`ifdef DN_LOADER_PARITY_EN
    logic r_par_acc;
    logic r_parity_err;

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            r_par_acc    <= 1'b0;
            r_parity_err <= 1'b0;
        end else if (w_start) begin
            r_par_acc    <= 1'b0;
            r_parity_err <= 1'b0;
        end else if (w_accept) begin
            r_par_acc <= r_par_acc ^ src_data;
            if (w_last) begin
                r_parity_err <= r_par_acc ^ src_data ^ src_parity;
            end
        end
    end

    assign parity_err = r_parity_err;
`endif

endmodule
